// File: rtl/cola_destinos_externos_pkg.sv
// rtl/cola_destinos_externos_pkg.sv - elevator-wide floor codes and destination table defaults
package cola_destinos_externos_pkg;

  // Floor codes carried on the 2-bit destination bus
  localparam logic [1:0] PISO_M1 = 2'b00;
  localparam logic [1:0] PISO_1  = 2'b01;
  localparam logic [1:0] PISO_2  = 2'b10;
  localparam logic [1:0] PISO_3  = 2'b11;

  // Dispatcher-side code meaning "no pending destination"
  localparam logic [2:0] SIN_DESTINO = 3'b100;

  // Table geometry; the dispatcher saturates its index at FINFIFO
  localparam int DEPTH_DEF  = 10;
  localparam int ADDR_W_DEF = 10;
  localparam int FINFIFO    = DEPTH_DEF - 1;

  // Default call sequence loaded at power-up and on every reset
  function automatic logic [1:0] destino_defecto(input int idx);
    logic [1:0] d;
    case (idx)
      0:       d = PISO_1;
      1:       d = PISO_3;
      2:       d = PISO_M1;
      3:       d = PISO_2;
      4:       d = PISO_3;
      5:       d = PISO_1;
      6:       d = PISO_M1;
      7:       d = PISO_3;
      8:       d = PISO_2;
      9:       d = PISO_1;
      default: d = PISO_M1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cola_destinos_externos_if.sv
// rtl/cola_destinos_externos_if.sv - read/write bus between dispatcher (or host) and destination table
interface cola_destinos_externos_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic [1:0]        destino;
  logic              valido;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;

  modport master (
    output address, wr_en, wr_addr, wr_data,
    input  destino, valido
  );

  modport slave (
    input  address, wr_en, wr_addr, wr_data,
    output destino, valido
  );
endinterface

// File: rtl/cola_destinos_externos.sv
// rtl/cola_destinos_externos.sv - external floor-call destination table with combinational read
module cola_destinos_externos
  import cola_destinos_externos_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  cola_destinos_externos_if.slave bus
);

  typedef logic [1:0] tabla_t [DEPTH];

  function automatic tabla_t tabla_defecto();
    tabla_t t;
    for (int i = 0; i < DEPTH; i++) begin
      t[i] = destino_defecto(i);
    end
    return t;
  endfunction

  // Array starts out holding the default sequence so it is usable before any reset
  tabla_t r_mem = tabla_defecto();

  logic [1:0] w_destino;
  logic       w_valido;

  // Reset reloads defaults and wins over a same-cycle write; out-of-range writes match no entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= destino_defecto(i);
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) begin
          r_mem[i] <= bus.wr_data;
        end
      end
    end
  end

  // Full-width address compare: anything outside 0..DEPTH-1 reads as floor -1 and invalid
  always_comb begin
    w_destino = PISO_M1;
    w_valido  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.address == ADDR_W'(i)) begin
        w_destino = r_mem[i];
        w_valido  = 1'b1;
      end
    end
  end

  assign bus.destino = w_destino;
  assign bus.valido  = w_valido;

endmodule

// File: tb/tb_cola_destinos_externos.sv
// tb/tb_cola_destinos_externos.sv - directed self-checking bench for the destination table
module tb_cola_destinos_externos;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [1:0] esperado [10];

  cola_destinos_externos_if #(.ADDR_W(10)) bus ();

  cola_destinos_externos #(.DEPTH(10), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic verificar(input string tag, input logic [31:0] obtenido, input logic [31:0] requerido);
    checks++;
    if (obtenido !== requerido) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obtenido, requerido);
    end
  endtask

  task automatic leer(input string tag, input logic [9:0] addr, input logic [1:0] dest, input logic val);
    bus.address = addr;
    #1;
    verificar(tag, {29'd0, bus.valido, bus.destino}, {29'd0, val, dest});
  endtask

  task automatic barrido(input string tag);
    for (int i = 0; i < 10; i++) begin
      leer($sformatf("%s[%0d]", tag, i), 10'(i), esperado[i], 1'b1);
    end
  endtask

  task automatic cargar_defectos();
    esperado[0] = 2'b01; esperado[1] = 2'b11; esperado[2] = 2'b00; esperado[3] = 2'b10;
    esperado[4] = 2'b11; esperado[5] = 2'b01; esperado[6] = 2'b00; esperado[7] = 2'b11;
    esperado[8] = 2'b10; esperado[9] = 2'b01;
  endtask

  task automatic escribir(input logic [9:0] addr, input logic [1:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    bus.address = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 2'b00;
    cargar_defectos();

    // Power-up contents before any reset
    @(negedge clk);
    leer("powerup_1", 10'd1, 2'b11, 1'b1);

    // Reset then sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    barrido("reset_sweep");

    // Out-of-range reads
    leer("oor_10",   10'd10,   2'b00, 1'b0);
    leer("oor_1023", 10'd1023, 2'b00, 1'b0);
    leer("oor_512",  10'd512,  2'b00, 1'b0);

    // Read-during-write on entry 3: old value before the edge, new value after
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'd3;
    bus.wr_data = 2'b01;
    leer("rdw_before", 10'd3, 2'b10, 1'b1);
    @(posedge clk);
    #1;
    verificar("rdw_after", {29'd0, bus.valido, bus.destino}, 32'h5);
    @(negedge clk);
    bus.wr_en = 1'b0;
    esperado[3] = 2'b01;
    barrido("after_write3");

    // Write to an out-of-range index is ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cargar_defectos();
    escribir(10'd10, 2'b11);
    barrido("ignored_write");

    // Reset has priority over a same-cycle write
    @(negedge clk);
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'd0;
    bus.wr_data = 2'b10;
    @(negedge clk);
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    leer("rst_priority", 10'd0, 2'b01, 1'b1);

    // Mid-sequence reset undoes prior writes
    escribir(10'd1, 2'b00);
    escribir(10'd9, 2'b00);
    leer("pre_rst_1", 10'd1, 2'b00, 1'b1);
    leer("pre_rst_9", 10'd9, 2'b00, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    leer("mid_rst_1", 10'd1, 2'b11, 1'b1);
    leer("mid_rst_9", 10'd9, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cola_destinos_externos.md
Name: cola_destinos_externos

Overview:
- Table of external floor-call destinations, indexed by an address that the elevator dispatcher (controlador_ascensores) advances, saturating at entry 9.
- Holds DEPTH 2-bit floor codes. It powers up and resets to a fixed default call sequence.
- Has a synchronous write port so a bench or host can reprogram entries.
- Read is combinational, so the dispatcher sees the entry for the current address in the same cycle.

Parameters:
- DEPTH, 10: number of table entries. The valid index range is 0..DEPTH-1, matching dispatcher FINFIFO = 9.
- ADDR_W, 10: width of the read and write address ports.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  ADDR_W  read index, driven by the dispatcher.
- destino  output  2  floor code at address. Encoding: 00 = floor -1, 01 = floor 1, 10 = floor 2, 11 = floor 3.
- valido  output  1  high when address < DEPTH.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  2  floor code to store.

Behaviour:
- Storage: DEPTH x 2-bit registers.
- Default contents, index 0..9: 01, 11, 00, 10, 11, 01, 00, 11, 10, 01.
- Reset:
  - On a rising clk edge with rst = 1, every entry reloads its default value.
  - rst has priority over wr_en in the same cycle; the write is dropped.
  - Asserting rst mid-sequence restores the defaults on the next edge regardless of prior writes.
- Power-up: the register array is initialised to the default contents, so the block is usable before the first reset.
- Read:
  - Purely combinational, zero latency: destino = entry[address] and valido = 1 when address < DEPTH.
  - When address >= DEPTH: destino = 00 and valido = 0. No wrap-around and no modulo indexing; all ADDR_W bits are compared.
- Write:
  - On a rising edge with rst = 0, wr_en = 1 and wr_addr < DEPTH, entry[wr_addr] <= wr_data.
  - Writes with wr_addr >= DEPTH are silently ignored and change no entry.
- Read-during-write to the same index:
  - destino shows the old value until the edge and the new value immediately after it (combinationally, in the following cycle).
  - There is no write-through bypass.
- No other state, no full/empty flags, no internal pointer. Address sequencing is entirely the dispatcher's job.
- Outputs depend only on the array contents and address. The block has no X-propagation paths after initialisation.

Decomposition:
- Shared package (elevator-wide), containing:
  - floor-code constants PISO_M1 = 00, PISO_1 = 01, PISO_2 = 10, PISO_3 = 11;
  - dispatcher "no destination" code 100;
  - DEPTH/FINFIFO relationship (FINFIFO = DEPTH-1);
  - default-contents constant array.
- No sub-module. The block is a single register file with a combinational read mux and reset-load logic.

Test Plan:
- Reset then sweep: assert rst 1 cycle, then drive address 0..9 -> destino = 01, 11, 00, 10, 11, 01, 00, 11, 10, 01 with valido = 1 at each.
- Out-of-range reads:
  - address = 10 -> destino = 00, valido = 0.
  - address = 1023 -> destino = 00, valido = 0.
  - address = 512 -> destino = 00, valido = 0 (no aliasing to index 0).
- Write then read: wr_en = 1, wr_addr = 3, wr_data = 01 for one edge; with address = 3 -> destino = 10 before the edge, 01 after the edge. Other entries are unchanged.
- Ignored write: wr_en = 1, wr_addr = 10, wr_data = 11 -> full sweep 0..9 still matches the defaults.
- Reset priority: rst = 1 and wr_en = 1, wr_addr = 0, wr_data = 10 in the same cycle -> entry 0 reads 01 after the edge.
- Mid-sequence reset: write 00 to entries 1 and 9, assert rst -> entries 1 and 9 read 11 and 01 again.
